// File: rtl/ip4_sm_ctl.sv
// Shared-memory bank controller.
// Serves client read/write requests against a single-port bank with a
// one-cycle read latency. Read data returns through a 2-entry response FIFO
// with a same-cycle bypass. Also zero-fills the whole bank on request.
module ip4_sm_ctl #(
   parameter int unsigned WID_ADR  = 12,
   parameter int unsigned WID_WORD = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   // client request
   input  logic                req_vld,
   output logic                req_rdy,
   input  logic                req_wr,
   input  logic [WID_ADR-1:0]  req_adr,
   input  logic [WID_WORD-1:0] req_dat,
   // client read response
   output logic                rsp_vld,
   input  logic                rsp_rdy,
   output logic [WID_WORD-1:0] rsp_dat,
   // bank zero-fill
   input  logic                init_go,
   output logic                init_busy,
   // bank port
   output logic                bk_wr,
   output logic [WID_ADR-1:0]  bk_adr,
   output logic [WID_WORD-1:0] bk_datai,
   input  logic [WID_WORD-1:0] bk_datao
);

   typedef enum logic [1:0] {
      StIdle,
      StDrain,
      StInit
   } state_e;

   state_e              state_q, state_d;
   logic [WID_ADR-1:0]  init_cnt_q, init_cnt_d;
   logic                inflight_q, inflight_d;

   // response FIFO
   logic [WID_WORD-1:0] fifo_q [2];
   logic                rd_ptr_q, wr_ptr_q;
   logic [1:0]          occ_q, occ_d;

   logic [1:0]          credit;
   logic                accept;
   logic                fifo_empty;
   logic                pop;
   logic                pop_fifo;
   logic                push;

   // credit counts both buffered data and the read whose data lands this cycle
   assign credit     = occ_q + 2'(inflight_q);
   assign fifo_empty = (occ_q == 2'd0);

   // FSM next state, request handshake and bank port drive
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      req_rdy    = 1'b0;
      init_busy  = 1'b0;
      bk_wr      = 1'b0;
      bk_adr     = req_adr;
      bk_datai   = req_dat;
      accept     = 1'b0;
      unique case (state_q)
         StIdle: begin
            // rst_n gating keeps the handshake closed while reset is held
            req_rdy = rst_n & ~init_go & (req_wr | (credit < 2'd2));
            accept  = req_vld & req_rdy;
            bk_wr   = accept & req_wr;
            if (init_go) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            init_busy = 1'b1;
            if (!inflight_q) begin
               state_d = StInit;
            end
         end
         StInit: begin
            init_busy  = 1'b1;
            bk_wr      = 1'b1;
            bk_adr     = init_cnt_q;
            bk_datai   = '0;
            init_cnt_d = init_cnt_q + WID_ADR'(1);
            if (init_cnt_q == {WID_ADR{1'b1}}) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // response path: FIFO head first, otherwise bypass the landing bank data
   always_comb begin
      rsp_vld = ~fifo_empty | inflight_q;
      rsp_dat = '0;
      if (!fifo_empty) begin
         rsp_dat = fifo_q[rd_ptr_q];
      end else if (inflight_q) begin
         rsp_dat = bk_datao;
      end
      pop        = rsp_vld & rsp_rdy;
      pop_fifo   = pop & ~fifo_empty;
      // landing data consumed directly through the bypass is not stored
      push       = inflight_q & ~(pop & fifo_empty);
      inflight_d = accept & ~req_wr;
      occ_d      = occ_q + 2'(push) - 2'(pop_fifo);
   end

   // FSM and init counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         init_cnt_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         inflight_q <= inflight_d;
      end
   end

   // response FIFO storage and pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         occ_q     <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= bk_datao;
         end
         wr_ptr_q <= wr_ptr_q ^ push;
         rd_ptr_q <= rd_ptr_q ^ pop_fifo;
         occ_q    <= occ_d;
      end
   end

endmodule

// File: tb/tb_ip4_sm_ctl.sv
// Self-checking bench for ip4_sm_ctl with a behavioural bank model.
module tb_ip4_sm_ctl;

   localparam int WA = 12;
   localparam int WW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_vld, req_rdy, req_wr;
   logic [WA-1:0] req_adr;
   logic [WW-1:0] req_dat;
   logic          rsp_vld, rsp_rdy;
   logic [WW-1:0] rsp_dat;
   logic          init_go, init_busy;
   logic          bk_wr;
   logic [WA-1:0] bk_adr;
   logic [WW-1:0] bk_datai, bk_datao;

   always #5 clk = ~clk;

   ip4_sm_ctl #(.WID_ADR(WA), .WID_WORD(WW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_vld   (req_vld),
      .req_rdy   (req_rdy),
      .req_wr    (req_wr),
      .req_adr   (req_adr),
      .req_dat   (req_dat),
      .rsp_vld   (rsp_vld),
      .rsp_rdy   (rsp_rdy),
      .rsp_dat   (rsp_dat),
      .init_go   (init_go),
      .init_busy (init_busy),
      .bk_wr     (bk_wr),
      .bk_adr    (bk_adr),
      .bk_datai  (bk_datai),
      .bk_datao  (bk_datao)
   );

   // bank: synchronous write, registered read (data one cycle after address)
   logic [WW-1:0] bank [1<<WA];
   always @(posedge clk) begin
      if (bk_wr) bank[bk_adr] <= bk_datai;
      bk_datao <= bank[bk_adr];
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          vld;
      logic          wr;
      logic [WA-1:0] adr;
      logic [WW-1:0] dat;
      logic          rr;
      logic          e_rdy;
      logic          e_bkwr;
      logic          e_rvld;
      logic [WW-1:0] e_rdat;
   } vec_t;

   vec_t vq[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nwr, bad, found;
      logic [WW-1:0] ref_mem [32];
      logic [WW-1:0] exq[$];
      logic          hold;
      logic [WW-1:0] hold_dat;

      for (int i = 0; i < (1 << WA); i++) bank[i] = 32'hA500_0000 | i;

      // reset: outputs quiet even with a write request presented
      rst_n = 1'b0; req_vld = 1'b1; req_wr = 1'b1; req_adr = '0; req_dat = 32'h1;
      rsp_rdy = 1'b1; init_go = 1'b0;
      #12;
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_bk_wr", bk_wr, 0);
      chk("rst_init_busy", init_busy, 0);
      chk("rst_rsp_dat", rsp_dat, 0);
      @(negedge clk);
      rst_n = 1'b1; req_vld = 1'b0; req_wr = 1'b0;
      #1;
      chk("post_rst_rdy", req_rdy, 1);
      cyc();

      //          vld   wr    adr      dat            rr    rdy   bkwr  rvld  rdat
      vq.push_back('{1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0});
      vq.push_back('{1'b1, 1'b0, 12'h010, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
      vq.push_back('{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF});
      vq.push_back('{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
      vq.push_back('{1'b1, 1'b0, 12'h001, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
      vq.push_back('{1'b1, 1'b0, 12'h002, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hA5000001});
      vq.push_back('{1'b1, 1'b0, 12'h003, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hA5000001});
      vq.push_back('{1'b1, 1'b0, 12'h003, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hA5000001});
      vq.push_back('{1'b1, 1'b1, 12'h030, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5000001});
      vq.push_back('{1'b1, 1'b0, 12'h003, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hA5000001});
      vq.push_back('{1'b1, 1'b0, 12'h003, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hA5000002});
      vq.push_back('{1'b1, 1'b0, 12'h004, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hA5000003});
      vq.push_back('{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hA5000004});
      vq.push_back('{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
      vq.push_back('{1'b1, 1'b1, 12'h020, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0});
      vq.push_back('{1'b1, 1'b0, 12'h020, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
      vq.push_back('{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678});
      vq.push_back('{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678});
      vq.push_back('{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0});

      foreach (vq[i]) begin
         req_vld = vq[i].vld; req_wr = vq[i].wr; req_adr = vq[i].adr;
         req_dat = vq[i].dat; rsp_rdy = vq[i].rr;
         @(negedge clk);
         chk($sformatf("v%0d_req_rdy", i), req_rdy, vq[i].e_rdy);
         chk($sformatf("v%0d_bk_wr", i), bk_wr, vq[i].e_bkwr);
         if (vq[i].e_bkwr) chk($sformatf("v%0d_bk_adr", i), bk_adr, vq[i].adr);
         chk($sformatf("v%0d_rsp_vld", i), rsp_vld, vq[i].e_rvld);
         if (vq[i].e_rvld) chk($sformatf("v%0d_rsp_dat", i), rsp_dat, vq[i].e_rdat);
         cyc();
      end

      // init with a read in flight; init_go beats a same-cycle request
      req_vld = 1'b1; req_wr = 1'b0; req_adr = 12'h005; rsp_rdy = 1'b0;
      @(negedge clk);
      chk("pre_init_rdy", req_rdy, 1);
      cyc();
      init_go = 1'b1; req_adr = 12'h006;
      @(negedge clk);
      chk("go_req_rdy", req_rdy, 0);
      chk("go_bk_wr", bk_wr, 0);
      chk("go_busy", init_busy, 0);
      chk("go_rsp_vld", rsp_vld, 1);
      chk("go_rsp_dat", rsp_dat, 32'hA5000005);
      cyc();
      init_go = 1'b0; req_vld = 1'b0; rsp_rdy = 1'b1;
      @(negedge clk);
      chk("drain_busy", init_busy, 1);
      chk("drain_req_rdy", req_rdy, 0);
      chk("drain_bk_wr", bk_wr, 0);
      chk("drain_rsp_vld", rsp_vld, 1);
      chk("drain_rsp_dat", rsp_dat, 32'hA5000005);
      cyc();
      nwr = 0; bad = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (!init_busy) break;
         if (bk_wr) begin
            if (bk_adr !== WA'(nwr) || bk_datai !== '0) bad++;
            nwr++;
         end else bad++;
         if (rsp_vld || req_rdy) bad++;
      end
      chk("init_done", init_busy, 0);
      chk("init_nwr", nwr, 4096);
      chk("init_bad", bad, 0);
      req_vld = 1'b1; req_wr = 1'b0; req_adr = 12'hFFF;
      #1;
      chk("after_init_rdy", req_rdy, 1);
      cyc();
      req_vld = 1'b0;
      @(negedge clk);
      chk("fff_rsp_vld", rsp_vld, 1);
      chk("fff_rsp_dat", rsp_dat, 0);
      cyc();

      // reset in the middle of a fill
      init_go = 1'b1;
      cyc();
      init_go = 1'b0;
      found = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (init_busy && bk_wr && bk_adr == 12'h200) begin
            found = 1;
            break;
         end
      end
      chk("midinit_found", found, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", init_busy, 0);
      chk("midrst_bk_wr", bk_wr, 0);
      chk("midrst_req_rdy", req_rdy, 0);
      chk("midrst_rsp_vld", rsp_vld, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_req_rdy", req_rdy, 1);
      chk("rel_busy", init_busy, 0);
      @(negedge clk);
      chk("rel2_busy", init_busy, 0);
      chk("rel2_bk_wr", bk_wr, 0);
      cyc();

      // full fill so the reference model starts from known zeros
      init_go = 1'b1;
      cyc();
      init_go = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (!init_busy) break;
      end
      chk("fill2_done", init_busy, 0);
      cyc();
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;

      // random traffic against the reference memory
      hold = 1'b0; hold_dat = '0;
      for (int n = 0; n < 10000; n++) begin
         req_vld = 1'($urandom_range(0, 1));
         req_wr  = 1'($urandom_range(0, 1));
         req_adr = WA'($urandom_range(0, 31));
         req_dat = $urandom;
         rsp_rdy = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (hold) begin
            chk("rnd_stable_vld", rsp_vld, 1);
            chk("rnd_stable_dat", rsp_dat, hold_dat);
         end
         if (rsp_vld && rsp_rdy) begin
            if (exq.size() == 0) begin
               checks++; errors++;
               $display("FAIL rnd_extra_rsp: got %h expected none", rsp_dat);
            end else begin
               chk("rnd_rsp_dat", rsp_dat, exq.pop_front());
            end
         end
         if (req_vld && req_rdy) begin
            if (req_wr) ref_mem[req_adr[4:0]] = req_dat;
            else exq.push_back(ref_mem[req_adr[4:0]]);
         end
         hold = rsp_vld && !rsp_rdy;
         hold_dat = rsp_dat;
         cyc();
      end
      req_vld = 1'b0; rsp_rdy = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_vld) begin
            if (exq.size() == 0) begin
               checks++; errors++;
               $display("FAIL rnd_drain_extra: got %h expected none", rsp_dat);
            end else begin
               chk("rnd_drain_dat", rsp_dat, exq.pop_front());
            end
         end
         cyc();
      end
      chk("rnd_left", exq.size(), 0);
      @(negedge clk);
      chk("rnd_end_vld", rsp_vld, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
